// File: rtl/uart_packet_parser_if.sv
// uart_packet_parser_if
// Purpose: groups the byte-stream input and the servo-target outputs of
//          uart_packet_parser into one bundle.
// Signals:
//    rx_data      [7:0]  byte from the UART receiver
//    rx_valid            one-cycle strobe qualifying rx_data
//    x_target     [7:0]  pan target for the servo stage
//    y_target     [7:0]  tilt target for the servo stage
//    target_valid        one-cycle pulse when the targets update
//    track_lost          high while no good packet has arrived recently
//    err_count    [7:0]  saturating count of checksum failures and timeouts
// Modports:
//    master  byte source / target consumer (drives rx_*)
//    slave   the parser itself (drives the target outputs)
interface uart_packet_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] x_target;
   logic [7:0] y_target;
   logic       target_valid;
   logic       track_lost;
   logic [7:0] err_count;

   modport master (
      output rx_data,
      output rx_valid,
      input  x_target,
      input  y_target,
      input  target_valid,
      input  track_lost,
      input  err_count
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output x_target,
      output y_target,
      output target_valid,
      output track_lost,
      output err_count
   );
endinterface

// File: rtl/uart_packet_parser.sv
// uart_packet_parser
// Purpose: parses four-byte packets {HEADER, X, Y, CK} arriving from a UART
//          receiver, where CK = (X + Y) mod 256, and turns good packets into
//          pan/tilt servo targets. Bytes that stall mid-packet and bad
//          checksums are counted as errors; a long silence without a good
//          packet declares tracking lost and recentres the targets.
// Parameters:
//    BYTE_TIMEOUT_CYC  max cycles allowed between bytes of one packet
//    LOST_TIMEOUT_CYC  cycles without a good packet before track_lost
//    HEADER            packet start byte
//    INVERT_X          1: x_target = 255 - X, 0: x_target = X
// Ports:
//    clk50mhz  system clock, rising edge
//    rst_n     synchronous active-low reset
//    bus       uart_packet_parser_if.slave (rx_data/rx_valid in, targets out)
module uart_packet_parser #(
   parameter int unsigned BYTE_TIMEOUT_CYC = 2_500_000,
   parameter int unsigned LOST_TIMEOUT_CYC = 25_000_000,
   parameter logic [7:0]  HEADER           = 8'hAA,
   parameter int unsigned INVERT_X         = 1
) (
   input  logic                 clk50mhz,
   input  logic                 rst_n,
   uart_packet_parser_if.slave  bus
);

   localparam int BYTE_CNT_W = $clog2(BYTE_TIMEOUT_CYC + 1);
   localparam int LOST_CNT_W = $clog2(LOST_TIMEOUT_CYC + 1);

   // The byte timer fires on the edge where it would reach the limit, so the
   // compare is against limit-1; the lost counter parks at the limit itself.
   localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(BYTE_TIMEOUT_CYC - 1);
   localparam logic [LOST_CNT_W-1:0] LOST_LAST = LOST_CNT_W'(LOST_TIMEOUT_CYC - 1);
   localparam logic [LOST_CNT_W-1:0] LOST_MAX  = LOST_CNT_W'(LOST_TIMEOUT_CYC);
   localparam logic [7:0]            CENTRE    = 8'd128;

   typedef enum logic [1:0] {IDLE, GET_X, GET_Y, GET_CK} state_t;

   state_t                state;
   logic [7:0]            x_hold;
   logic [7:0]            y_hold;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic [LOST_CNT_W-1:0] lost_cnt;

   logic [7:0] ck_expected;
   logic [7:0] x_new;
   logic       good_packet;
   logic       bad_packet;
   logic       byte_timeout;

   // Packet evaluation happens on the checksum strobe itself; a strobe on the
   // would-be timeout cycle suppresses the timeout so the byte wins.
   assign ck_expected  = x_hold + y_hold;
   assign x_new        = (INVERT_X != 0) ? (8'hFF - x_hold) : x_hold;
   assign good_packet  = bus.rx_valid && (state == GET_CK) && (bus.rx_data == ck_expected);
   assign bad_packet   = bus.rx_valid && (state == GET_CK) && (bus.rx_data != ck_expected);
   assign byte_timeout = !bus.rx_valid && (state != IDLE) && (byte_cnt == BYTE_LAST);

   // Packet FSM, inter-byte timer, error counter and target/lost tracking.
   // A good packet outranks lost-timer expiry on the same edge.
   always_ff @(posedge clk50mhz) begin
      if (!rst_n) begin
         state            <= IDLE;
         x_hold           <= '0;
         y_hold           <= '0;
         byte_cnt         <= '0;
         lost_cnt         <= '0;
         bus.x_target     <= CENTRE;
         bus.y_target     <= CENTRE;
         bus.target_valid <= 1'b0;
         bus.track_lost   <= 1'b1;
         bus.err_count    <= '0;
      end else begin
         bus.target_valid <= 1'b0;

         if (bus.rx_valid) begin
            byte_cnt <= '0;
            case (state)
               IDLE: begin
                  if (bus.rx_data == HEADER) begin
                     state <= GET_X;
                  end
               end
               GET_X: begin
                  x_hold <= bus.rx_data;
                  state  <= GET_Y;
               end
               GET_Y: begin
                  y_hold <= bus.rx_data;
                  state  <= GET_CK;
               end
               GET_CK: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end else if (state != IDLE) begin
            if (byte_timeout) begin
               state    <= IDLE;
               byte_cnt <= '0;
            end else begin
               byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            end
         end

         if ((bad_packet || byte_timeout) && (bus.err_count != 8'hFF)) begin
            bus.err_count <= bus.err_count + 8'd1;
         end

         if (good_packet) begin
            bus.x_target     <= x_new;
            bus.y_target     <= y_hold;
            bus.target_valid <= 1'b1;
            bus.track_lost   <= 1'b0;
            lost_cnt         <= '0;
         end else if (lost_cnt == LOST_LAST) begin
            lost_cnt       <= LOST_MAX;
            bus.track_lost <= 1'b1;
            bus.x_target   <= CENTRE;
            bus.y_target   <= CENTRE;
         end else if (lost_cnt != LOST_MAX) begin
            lost_cnt <= lost_cnt + LOST_CNT_W'(1);
         end
      end
   end

endmodule
